vector_regfile_banked: RTL and testbench

//  Second-generation vector register file for the vector coprocessor datapath.

---
 rtl/vrf_pkg.sv | 37 +++
 rtl/vrf_sweep_seq.sv | 78 +++++++
 rtl/vector_regfile_banked.sv | 139 +++++++++++++
 tb/tb_vector_regfile_banked.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared types and helpers for the banked vector register file.
// Build option: VRF_BYPASS_EN (used by vector_regfile_banked).
package vrf_pkg;

    typedef enum logic [1:0] {
        VRF_INIT,
        VRF_IDLE,
        VRF_CLEAR
    } vrf_state_t;

    // Widest element the byte-merge helper can handle.
    localparam int VRF_MAX_DW = 256;

    function automatic int vrf_reg_aw(input int num_reg);
        return (num_reg > 1) ? $clog2(num_reg) : 1;
    endfunction

    function automatic int vrf_ele_aw(input int num_ele);
        return (num_ele > 1) ? $clog2(num_ele) : 1;
    endfunction

    function automatic logic [VRF_MAX_DW-1:0] merge(
        input logic [VRF_MAX_DW-1:0]   old_data,
        input logic [VRF_MAX_DW-1:0]   new_data,
        input logic [VRF_MAX_DW/8-1:0] mask
    );
        logic [VRF_MAX_DW-1:0] result;
        result = old_data;
        for (int i = 0; i < VRF_MAX_DW / 8; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vrf_sweep_seq.sv
// Sweep sequencer for the vector register file: INIT/IDLE/CLEAR FSM, the
// element counter, the latched clear target and the handshake readies.
module vrf_sweep_seq
    import vrf_pkg::*;
#(
    parameter int NUM_ELE = 32,
    parameter int REG_AW  = 3,
    parameter int ELE_AW  = vrf_ele_aw(NUM_ELE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_reg,
    output logic              sweep_init,
    output logic              sweep_clear,
    output logic [ELE_AW-1:0] cnt,
    output logic [REG_AW-1:0] clr_target,
    output logic              busy,
    output logic              wr_ready,
    output logic              clr_ready
);

    localparam logic [ELE_AW-1:0] CNT_LAST = ELE_AW'(NUM_ELE - 1);

    vrf_state_t        state_q, state_d;
    logic [ELE_AW-1:0] cnt_q, cnt_d;
    logic [REG_AW-1:0] target_q, target_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= VRF_INIT;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // Readies are masked by reset so nothing is accepted on a reset edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        busy      = 1'b1;
        wr_ready  = 1'b0;
        clr_ready = 1'b0;
        unique case (state_q)
            VRF_INIT, VRF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = VRF_IDLE;
                end
            end
            VRF_IDLE: begin
                busy      = 1'b0;
                wr_ready  = !reset;
                clr_ready = !reset;
                if (clr_valid && !reset) begin
                    state_d  = VRF_CLEAR;
                    cnt_d    = '0;
                    target_d = clr_reg;
                end
            end
            default: begin
                state_d = VRF_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign sweep_init  = (state_q == VRF_INIT);
    assign sweep_clear = (state_q == VRF_CLEAR);
    assign cnt         = cnt_q;
    assign clr_target  = target_q;

endmodule

// File: rtl/vector_regfile_banked.sv
// Banked vector register file: byte-masked write port, two registered read
// ports, sweep-based init/clear. Define VRF_BYPASS_EN for write-to-read bypass.
module vector_regfile_banked
    import vrf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG    = 6,
    parameter int NUM_ELE    = 32,
    parameter int REG_AW     = vrf_reg_aw(NUM_REG),
    parameter int ELE_AW     = vrf_ele_aw(NUM_ELE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [REG_AW-1:0]       wr_reg,
    input  logic [ELE_AW-1:0]       wr_ele,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    rd1_en,
    input  logic [REG_AW-1:0]       rd1_reg,
    input  logic [ELE_AW-1:0]       rd1_ele,
    output logic [DATA_WIDTH-1:0]   rd1_data,
    output logic                    rd1_valid,
    input  logic                    rd2_en,
    input  logic [REG_AW-1:0]       rd2_reg,
    input  logic [ELE_AW-1:0]       rd2_ele,
    output logic [DATA_WIDTH-1:0]   rd2_data,
    output logic                    rd2_valid,
    input  logic                    clr_valid,
    output logic                    clr_ready,
    input  logic [REG_AW-1:0]       clr_reg,
    output logic                    busy
);

    logic              sweep_init;
    logic              sweep_clear;
    logic [ELE_AW-1:0] cnt;
    logic [REG_AW-1:0] clr_target;

    vrf_sweep_seq #(
        .NUM_ELE(NUM_ELE),
        .REG_AW (REG_AW),
        .ELE_AW (ELE_AW)
    ) u_sweep (
        .clk        (clk),
        .reset      (reset),
        .clr_valid  (clr_valid),
        .clr_reg    (clr_reg),
        .sweep_init (sweep_init),
        .sweep_clear(sweep_clear),
        .cnt        (cnt),
        .clr_target (clr_target),
        .busy       (busy),
        .wr_ready   (wr_ready),
        .clr_ready  (clr_ready)
    );

    logic [DATA_WIDTH-1:0] mem [NUM_REG][NUM_ELE];

    logic                  wr_fire;
    logic                  wr_in_range;
    logic                  clr_in_range;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;

    assign wr_fire      = wr_valid && wr_ready;
    assign wr_in_range  = int'(wr_reg) < NUM_REG;
    assign clr_in_range = int'(clr_target) < NUM_REG;

    always_comb begin
        wr_old = '0;
        if (wr_in_range) begin
            wr_old = mem[wr_reg][wr_ele];
        end
    end

    assign wr_merged = DATA_WIDTH'(merge(VRF_MAX_DW'(wr_old), VRF_MAX_DW'(wr_data),
                                         (VRF_MAX_DW/8)'(wr_mask)));

    // The array has no reset; INIT zeroes it one element column per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_fire && wr_in_range) begin
                mem[wr_reg][wr_ele] <= wr_merged;
            end
            if (sweep_init) begin
                for (int r = 0; r < NUM_REG; r++) begin
                    mem[r][cnt] <= '0;
                end
            end
            if (sweep_clear && clr_in_range) begin
                mem[clr_target][cnt] <= '0;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_word(
        input logic [REG_AW-1:0] r,
        input logic [ELE_AW-1:0] e
    );
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        if (int'(r) < NUM_REG) begin
            word = mem[r][e];
`ifdef VRF_BYPASS_EN
            if (wr_fire && (wr_reg == r) && (wr_ele == e)) begin
                word = wr_merged;
            end
`endif
        end
        return word;
    endfunction

    logic rd1_en_q;
    logic rd2_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_data <= '0;
            rd2_data <= '0;
            rd1_en_q <= 1'b0;
            rd2_en_q <= 1'b0;
        end else begin
            rd1_en_q <= rd1_en;
            rd2_en_q <= rd2_en;
            if (rd1_en) begin
                rd1_data <= read_word(rd1_reg, rd1_ele);
            end
            if (rd2_en) begin
                rd2_data <= read_word(rd2_reg, rd2_ele);
            end
        end
    end

    assign rd1_valid = rd1_en_q && !sweep_init;
    assign rd2_valid = rd2_en_q && !sweep_init;

endmodule

// File: tb/tb_vector_regfile_banked.sv
// Scoreboard testbench for vector_regfile_banked: stimulus pushes expected
// read data into per-port queues, a negedge monitor pops and compares.
module tb_vector_regfile_banked;

    localparam int DW  = 32;
    localparam int RAW = 3;
    localparam int EAW = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [RAW-1:0] wr_reg = '0;
    logic [EAW-1:0] wr_ele = '0;
    logic [DW-1:0]  wr_data = '0;
    logic [3:0]     wr_mask = '0;
    logic           rd1_en = 1'b0;
    logic [RAW-1:0] rd1_reg = '0;
    logic [EAW-1:0] rd1_ele = '0;
    logic [DW-1:0]  rd1_data;
    logic           rd1_valid;
    logic           rd2_en = 1'b0;
    logic [RAW-1:0] rd2_reg = '0;
    logic [EAW-1:0] rd2_ele = '0;
    logic [DW-1:0]  rd2_data;
    logic           rd2_valid;
    logic           clr_valid = 1'b0;
    logic           clr_ready;
    logic [RAW-1:0] clr_reg = '0;
    logic           busy;

    vector_regfile_banked dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_reg   (wr_reg),
        .wr_ele   (wr_ele),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .rd1_en   (rd1_en),
        .rd1_reg  (rd1_reg),
        .rd1_ele  (rd1_ele),
        .rd1_data (rd1_data),
        .rd1_valid(rd1_valid),
        .rd2_en   (rd2_en),
        .rd2_reg  (rd2_reg),
        .rd2_ele  (rd2_ele),
        .rd2_data (rd2_data),
        .rd2_valid(rd2_valid),
        .clr_valid(clr_valid),
        .clr_ready(clr_ready),
        .clr_reg  (clr_reg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    int            rd_num1 = 0;
    int            rd_num2 = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every valid read beat consumes one expected entry.
    always @(negedge clk) begin
        if (rd1_valid === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check_output("rd1 unexpected valid", {31'b0, rd1_valid}, 32'd0);
            end else begin
                check_output($sformatf("rd1 read %0d", rd_num1), rd1_data, exp_q1.pop_front());
                rd_num1++;
            end
        end
        if (rd2_valid === 1'b1) begin
            if (exp_q2.size() == 0) begin
                check_output("rd2 unexpected valid", {31'b0, rd2_valid}, 32'd0);
            end else begin
                check_output($sformatf("rd2 read %0d", rd_num2), rd2_data, exp_q2.pop_front());
                rd_num2++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_write(input int r, input int e, input logic [31:0] d,
                               input logic [3:0] m);
        wr_valid = 1'b1;
        wr_reg   = RAW'(r);
        wr_ele   = EAW'(e);
        wr_data  = d;
        wr_mask  = m;
        check_output("wr_ready at write", {31'b0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic apply_read(input int r, input int e, input logic [31:0] expected);
        rd1_en  = 1'b1;
        rd1_reg = RAW'(r);
        rd1_ele = EAW'(e);
        rd2_en  = 1'b1;
        rd2_reg = RAW'(r);
        rd2_ele = EAW'(e);
        exp_q1.push_back(expected);
        exp_q2.push_back(expected);
        tick();
        rd1_en = 1'b0;
        rd2_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int expected_cycles);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_output({name, " busy cycles"}, n, expected_cycles);
        check_output({name, " wr_ready after sweep"}, {31'b0, wr_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " rd1_data"}, rd1_data, 32'd0);
        check_output({name, " rd1_valid"}, {31'b0, rd1_valid}, 32'd0);
        check_output({name, " busy"}, {31'b0, busy}, 32'd1);
        check_output({name, " wr_ready"}, {31'b0, wr_ready}, 32'd0);
        check_output({name, " clr_ready"}, {31'b0, clr_ready}, 32'd0);
    endtask

    initial begin
        $display("[TB] starting vector_regfile_banked bench");

        // Test 1: reset, INIT sweep length, read of last element.
        reset = 1'b1;
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        wait_idle("init", 32);
        apply_read(5, 31, 32'h0);

        // Test 2: full write then partial byte write.
        apply_write(2, 7, 32'hDEADBEEF, 4'hF);
        apply_write(2, 7, 32'h00001234, 4'h3);
        apply_read(2, 7, 32'hDEAD1234);
        tick();
        check_output("rd1_data hold", rd1_data, 32'hDEAD1234);
        apply_write(2, 7, 32'h55555555, 4'h0);
        apply_read(2, 7, 32'hDEAD1234);

        // Test 3: fill reg3, clear it together with a write to it.
        for (int e = 0; e < 32; e++) begin
            apply_write(3, e, 32'h3000_0000 + e, 4'hF);
        end
        for (int e = 0; e < 4; e++) begin
            apply_write(4, e, 32'h4400_00E0 + e, 4'hF);
        end
        clr_valid = 1'b1;
        clr_reg   = 3'd3;
        wr_valid  = 1'b1;
        wr_reg    = 3'd3;
        wr_ele    = 5'd0;
        wr_data   = 32'hFFFFFFFF;
        wr_mask   = 4'hF;
        check_output("clr_ready at clear", {31'b0, clr_ready}, 32'd1);
        tick();
        clr_valid = 1'b0;
        wr_valid  = 1'b0;
        check_output("clear busy", {31'b0, busy}, 32'd1);
        check_output("clear wr_ready", {31'b0, wr_ready}, 32'd0);
        check_output("clear clr_ready", {31'b0, clr_ready}, 32'd0);
        wait_idle("clear reg3", 32);
        for (int e = 0; e < 32; e++) begin
            apply_read(3, e, 32'h0);
        end
        for (int e = 0; e < 4; e++) begin
            apply_read(4, e, 32'h4400_00E0 + e);
        end

        // Test 4: write and read of the same location in one cycle.
        wr_valid = 1'b1;
        wr_reg   = 3'd1;
        wr_ele   = 5'd4;
        wr_data  = 32'hA5A5A5A5;
        wr_mask  = 4'hF;
`ifdef VRF_BYPASS_EN
        apply_read(1, 4, 32'hA5A5A5A5);
`else
        apply_read(1, 4, 32'h0);
`endif
        wr_valid = 1'b0;
        apply_read(1, 4, 32'hA5A5A5A5);

        // Test 6: out-of-range write, read and clear.
        apply_write(7, 0, 32'h12345678, 4'hF);
        apply_read(7, 0, 32'h0);
        apply_read(3, 0, 32'h0);
        apply_write(0, 1, 32'h0BADF00D, 4'hF);
        clr_valid = 1'b1;
        clr_reg   = 3'd7;
        tick();
        clr_valid = 1'b0;
        wait_idle("clear reg7", 32);
        apply_read(0, 1, 32'h0BADF00D);

        // Test 5: reset in the middle of a CLEAR sweep of reg4.
        clr_valid = 1'b1;
        clr_reg   = 3'd4;
        tick();
        clr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        check_reset_state("mid-clear reset");
        reset = 1'b0;
        wait_idle("re-init", 32);
        for (int r = 0; r < 6; r++) begin
            apply_read(r, 0, 32'h0);
            apply_read(r, 1, 32'h0);
            apply_read(r, 4, 32'h0);
            apply_read(r, 7, 32'h0);
            apply_read(r, 31, 32'h0);
        end

        tick();
        tick();
        check_output("rd1 scoreboard drained", exp_q1.size(), 32'd0);
        check_output("rd2 scoreboard drained", exp_q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
